// File: rtl/pair_detect_pkg.sv
// Shared definitions for the time-multiplexed equal-pair detector: state encoding
// and the pure next-state/output function applied to whichever channel is granted.
package pair_detect_pkg;

    localparam int unsigned PdStateW = 2;

    typedef enum logic [PdStateW-1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b11
    } pd_state_e;

    typedef struct packed {
        pd_state_e nxt;
        logic      b;
    } pd_step_t;

    // S1 remembers a pending 1, S2 a pending 0; a matching bit closes the pair.
    function automatic pd_step_t pd_step(input logic [PdStateW-1:0] s, input logic a);
        pd_step_t r;
        r.nxt = S0;
        r.b   = 1'b0;
        case (s)
            S0: r.nxt = a ? S1 : S2;
            S1: begin
                r.nxt = a ? S0 : S2;
                r.b   = a;
            end
            S2: begin
                r.nxt = a ? S1 : S0;
                r.b   = !a;
            end
            default: begin
                r.nxt = S0;
                r.b   = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pd_rr_arbiter.sv
// Round-robin arbiter: searches from the last granted channel + 1, wrapping, and
// emits a zero-or-one-hot grant plus its index; the pointer moves only on a grant.
module pd_rr_arbiter #(
    parameter int unsigned NCh = 4,
    parameter int unsigned ChW = $clog2(NCh)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NCh-1:0] req_i,
    input  logic           en_i,
    output logic [NCh-1:0] gnt_o,
    output logic           gnt_valid_o,
    output logic [ChW-1:0] gnt_idx_o
);

    logic [ChW-1:0] ptr_q, ptr_d;

    always_comb begin
        int  idx;
        logic found;
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        found       = 1'b0;
        idx         = 0;
        if (en_i) begin
            for (int k = 1; k <= int'(NCh); k++) begin
                idx = (int'(ptr_q) + k) % int'(NCh);
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_idx_o  = ChW'(idx);
                end
            end
        end
        gnt_valid_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = gnt_idx_o;
        end
    end

    // Reset to the last channel so channel 0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= ChW'(NCh - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pair_detect_sched.sv
// Shares one equal-pair Mealy detector among N_CH serial streams; one granted bit per
// cycle is stepped through its channel's stored state into a backpressured result slot.
module pair_detect_sched
    import pair_detect_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CH_W  = $clog2(N_CH),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req_valid,
    input  logic [N_CH-1:0]  req_bit,
    output logic [N_CH-1:0]  req_ready,
    input  logic [N_CH-1:0]  clr_ch,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_match,
    input  logic             out_ready,
    output logic [CNT_W-1:0] match_total
);

    pd_state_e        state_q [N_CH];
    pd_state_e        state_d [N_CH];
    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic             out_match_q, out_match_d;
    logic [CNT_W-1:0] match_total_q, match_total_d;

    logic [N_CH-1:0]  eligible;
    logic             slot_free;
    logic             gnt_valid;
    logic [CH_W-1:0]  gnt_idx;
    pd_step_t         step;

    // A channel being cleared this cycle must not also be stepped.
    assign eligible  = req_valid & ~clr_ch;
    assign slot_free = !out_valid_q || out_ready;

    pd_rr_arbiter #(
        .NCh (N_CH),
        .ChW (CH_W)
    ) u_arb (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (eligible),
        .en_i        (slot_free),
        .gnt_o       (req_ready),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign step = pd_step(state_q[gnt_idx], req_bit[gnt_idx]);

    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            state_d[i] = state_q[i];
            if (clr_ch[i]) begin
                state_d[i] = S0;
            end else if (gnt_valid && (gnt_idx == CH_W'(i))) begin
                state_d[i] = step.nxt;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_match_d = out_match_q;
        if (gnt_valid) begin
            out_valid_d = 1'b1;
            out_ch_d    = gnt_idx;
            out_match_d = step.b;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        match_total_d = match_total_q;
        if (out_valid_q && out_ready && out_match_q && (match_total_q != '1)) begin
            match_total_d = match_total_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i] <= S0;
            end
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
            out_match_q   <= 1'b0;
            match_total_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i] <= state_d[i];
            end
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            out_match_q   <= out_match_d;
            match_total_q <= match_total_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign out_match   = out_match_q;
    assign match_total = match_total_q;

endmodule
